// File: rtl/mem_arbiter_ctrl.sv
`timescale 1ns/1ps
// mem_arbiter_ctrl: shares one line-wide, word-addressed data memory between the I-cache refill
// path and the D-cache refill/write-through path. Round-robin grant, one transaction in flight,
// bounded wait on mem_ready with a sticky timeout flag.
module mem_arbiter_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_done_o,
    output logic [127:0]      ic_rdata_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [31:0]       dc_wdata_i,
    output logic              dc_done_o,
    output logic [127:0]      dc_rdata_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [127:0]      mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              timeout_err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e            state_q;
    logic              last_ic_q;   // 1: I-cache won the last grant, so D-cache is favoured next
    logic              owner_dc_q;
    logic [CntW-1:0]   cnt_q;
    logic              ic_done_q;
    logic              dc_done_q;
    logic [127:0]      ic_rdata_q;
    logic [127:0]      dc_rdata_q;
    logic              mem_read_en_q;
    logic              mem_write_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              timeout_err_q;

    logic              grant_dc_d;
    logic              grant_we_d;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] grant_addr_d;
    logic [31:0]       grant_wdata_d;

    // Grant decision and the transaction fields that would be latched on a grant this cycle.
    always_comb begin
        grant_dc_d    = dc_req_i & (~ic_req_i | last_ic_q);
        grant_we_d    = grant_dc_d & dc_we_i;
        req_addr      = grant_dc_d ? dc_addr_i : ic_addr_i;
        // Line reads fetch the whole aligned 4-word line; writes target the exact word.
        grant_addr_d  = grant_we_d ? req_addr : {req_addr[ADDR_W-1:2], 2'b00};
        grant_wdata_d = grant_dc_d ? dc_wdata_i : '0;
    end

    // Transaction sequencer IDLE -> ACCESS -> DONE with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            last_ic_q      <= 1'b0;
            owner_dc_q     <= 1'b0;
            cnt_q          <= '0;
            ic_done_q      <= 1'b0;
            dc_done_q      <= 1'b0;
            ic_rdata_q     <= '0;
            dc_rdata_q     <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            // Done is a single-cycle pulse; only the ACCESS exit raises it.
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ic_req_i || dc_req_i) begin
                        owner_dc_q     <= grant_dc_d;
                        last_ic_q      <= ~grant_dc_d;
                        mem_addr_q     <= grant_addr_d;
                        mem_wdata_q    <= grant_wdata_d;
                        mem_read_en_q  <= ~grant_we_d;
                        mem_write_en_q <= grant_we_d;
                        cnt_q          <= '0;
                        state_q        <= StAccess;
                    end
                end
                StAccess: begin
                    if (mem_ready_i) begin
                        if (mem_read_en_q) begin
                            if (owner_dc_q) dc_rdata_q <= mem_rdata_i;
                            else            ic_rdata_q <= mem_rdata_i;
                        end
                        mem_read_en_q  <= 1'b0;
                        mem_write_en_q <= 1'b0;
                        ic_done_q      <= ~owner_dc_q;
                        dc_done_q      <= owner_dc_q;
                        state_q        <= StDone;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        // Aborted read returns an all-zero line; writes leave rdata untouched.
                        if (mem_read_en_q) begin
                            if (owner_dc_q) dc_rdata_q <= '0;
                            else            ic_rdata_q <= '0;
                        end
                        mem_read_en_q  <= 1'b0;
                        mem_write_en_q <= 1'b0;
                        timeout_err_q  <= 1'b1;
                        ic_done_q      <= ~owner_dc_q;
                        dc_done_q      <= owner_dc_q;
                        state_q        <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ic_done_o      = ic_done_q;
    assign dc_done_o      = dc_done_q;
    assign ic_rdata_o     = ic_rdata_q;
    assign dc_rdata_o     = dc_rdata_q;
    assign mem_read_en_o  = mem_read_en_q;
    assign mem_write_en_o = mem_write_en_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
`timescale 1ns/1ps
// tb_mem_arbiter_ctrl: directed bench with a transaction scoreboard and a simple memory responder.
module tb_mem_arbiter_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [127:0] Junk   = {4{32'hBAD0_BAD0}};

    logic              clock = 1'b0;
    logic              reset;
    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_done_o;
    logic [127:0]      ic_rdata_o;
    logic              dc_req_i;
    logic              dc_we_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [31:0]       dc_wdata_i;
    logic              dc_done_o;
    logic [127:0]      dc_rdata_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [127:0]      mem_rdata_i;
    logic              mem_ready_i;
    logic              timeout_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          dc;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t         sb_q[$];
    logic [127:0] exp_rd_ic;
    logic [127:0] exp_rd_dc;

    always #5 clock = ~clock;

    mem_arbiter_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .ic_req_i       (ic_req_i),
        .ic_addr_i      (ic_addr_i),
        .ic_done_o      (ic_done_o),
        .ic_rdata_o     (ic_rdata_o),
        .dc_req_i       (dc_req_i),
        .dc_we_i        (dc_we_i),
        .dc_addr_i      (dc_addr_i),
        .dc_wdata_i     (dc_wdata_i),
        .dc_done_o      (dc_done_o),
        .dc_rdata_o     (dc_rdata_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ready_i    (mem_ready_i),
        .timeout_err_o  (timeout_err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Line content the memory returns for a given line address.
    function automatic logic [127:0] line_of(input logic [9:0] a);
        return {8'hA3, 14'h0, a, 32'hC0DE_0000 | {22'h0, a},
                ~{22'h0, a}, 32'h5A5A_5A5A ^ {22'h0, a}};
    endfunction

    task automatic issue_ic(input logic [9:0] addr);
        txn_t t;
        ic_addr_i = addr;
        ic_req_i  = 1'b1;
        t.dc = 1'b0; t.we = 1'b0; t.addr = {addr[9:2], 2'b00}; t.wdata = '0;
        sb_q.push_back(t);
    endtask

    task automatic issue_dc(input bit we, input logic [9:0] addr, input logic [31:0] wdata);
        txn_t t;
        dc_we_i    = we;
        dc_addr_i  = addr;
        dc_wdata_i = wdata;
        dc_req_i   = 1'b1;
        t.dc = 1'b1; t.we = we; t.addr = we ? addr : {addr[9:2], 2'b00}; t.wdata = wdata;
        sb_q.push_back(t);
    endtask

    // Wait for the next grant, act as memory with the given latency (0 = never ready), and
    // check the result against the oldest scoreboard entry.
    task automatic do_txn(input int lat, input bit perturb);
        txn_t        it;
        int          w = 0;
        int          en = 0;
        bit          bad_kind = 0;
        bit          bad_addr = 0;
        bit          bad_wdata = 0;
        bit          both_hi = 0;
        bit          early_done = 0;
        logic [31:0] wd0;
        while (!(mem_read_en_o || mem_write_en_o) && w < 6) begin
            tick();
            w++;
        end
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        it = sb_q.pop_front();
        if (!(mem_read_en_o || mem_write_en_o)) begin
            chk("grant_seen", 0, 1);
            if (it.dc) dc_req_i = 1'b0; else ic_req_i = 1'b0;
            return;
        end
        chk("mem_addr", mem_addr_o, it.addr);
        wd0 = mem_wdata_o;
        if (it.we) chk("mem_wdata", mem_wdata_o, it.wdata);
        for (int k = 1; k <= 40; k++) begin
            if (!(mem_read_en_o || mem_write_en_o)) break;
            en++;
            if (mem_read_en_o && mem_write_en_o) both_hi = 1'b1;
            if (mem_read_en_o !== ~it.we || mem_write_en_o !== it.we) bad_kind = 1'b1;
            if (mem_addr_o !== it.addr) bad_addr = 1'b1;
            if (mem_wdata_o !== wd0) bad_wdata = 1'b1;
            if (ic_done_o || dc_done_o) early_done = 1'b1;
            if (k == lat) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = line_of(it.addr);
            end
            if (perturb && k == 2) begin
                dc_addr_i  = ~dc_addr_i;
                dc_we_i    = ~dc_we_i;
                dc_wdata_i = 32'hFFFF_0000;
                ic_addr_i  = ~ic_addr_i;
            end
            tick();
            mem_ready_i = 1'b0;
            mem_rdata_i = Junk;
        end
        chk("en_cycles", en, (lat == 0) ? TIMEOUT : lat);
        chk("en_kind", bad_kind, 0);
        chk("both_en_high", both_hi, 0);
        chk("addr_stable", bad_addr, 0);
        chk("wdata_stable", bad_wdata, 0);
        chk("done_during_access", early_done, 0);
        // DONE cycle
        chk("done_owner", it.dc ? dc_done_o : ic_done_o, 1);
        chk("done_other", it.dc ? ic_done_o : dc_done_o, 0);
        if (!it.we) begin
            if (it.dc) exp_rd_dc = (lat == 0) ? '0 : line_of(it.addr);
            else       exp_rd_ic = (lat == 0) ? '0 : line_of(it.addr);
        end
        chk("ic_rdata", ic_rdata_o, exp_rd_ic);
        chk("dc_rdata", dc_rdata_o, exp_rd_dc);
        if (it.dc) dc_req_i = 1'b0; else ic_req_i = 1'b0;
        tick();
        chk("done_pulse_end", {ic_done_o, dc_done_o}, 0);
    endtask

    initial begin
        reset       = 1'b0;
        ic_req_i    = 1'b0;
        ic_addr_i   = '0;
        dc_req_i    = 1'b0;
        dc_we_i     = 1'b0;
        dc_addr_i   = '0;
        dc_wdata_i  = '0;
        mem_rdata_i = Junk;
        mem_ready_i = 1'b0;
        exp_rd_ic   = '0;
        exp_rd_dc   = '0;
        #1;
        chk("reset_ctrl", {mem_read_en_o, mem_write_en_o, mem_addr_o, mem_wdata_o,
                           ic_done_o, dc_done_o, timeout_err_o}, 0);
        chk("reset_ic_rdata", ic_rdata_o, 0);
        chk("reset_dc_rdata", dc_rdata_o, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single line read, 4-cycle latency
        issue_ic(10'h006);
        do_txn(4, 1'b0);

        // Single word write
        issue_dc(1'b1, 10'h013, 32'hDEAD_BEEF);
        do_txn(5, 1'b0);

        // Contention: both held, grants must alternate ic, dc, ic, dc
        issue_ic(10'h040);
        issue_dc(1'b0, 10'h0A7, 32'h0);
        do_txn(5, 1'b0);
        issue_ic(10'h081);
        do_txn(7, 1'b0);
        issue_dc(1'b1, 10'h0FF, 32'hCAFE_F00D);
        do_txn(9, 1'b0);
        do_txn(15, 1'b0);
        chk("no_err_before_timeout", timeout_err_o, 0);

        // Timeout, then a good transaction; the error flag stays set
        issue_ic(10'h3FF);
        do_txn(0, 1'b0);
        chk("timeout_err_set", timeout_err_o, 1);
        issue_dc(1'b0, 10'h010, 32'h0);
        do_txn(6, 1'b0);
        chk("timeout_err_sticky", timeout_err_o, 1);

        // Reset in the second ACCESS cycle
        ic_addr_i = 10'h1C9;
        ic_req_i  = 1'b1;
        tick();
        chk("t5_access", mem_read_en_o, 1);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_reset_ctrl", {mem_read_en_o, mem_write_en_o, mem_addr_o, mem_wdata_o,
                              ic_done_o, dc_done_o, timeout_err_o}, 0);
        chk("t5_reset_ic_rdata", ic_rdata_o, 0);
        chk("t5_reset_dc_rdata", dc_rdata_o, 0);
        ic_req_i  = 1'b0;
        exp_rd_ic = '0;
        exp_rd_dc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_done", {ic_done_o, dc_done_o, mem_read_en_o, mem_write_en_o}, 0);
        end
        reset = 1'b1;
        tick();
        issue_ic(10'h1C9);
        do_txn(4, 1'b0);
        issue_dc(1'b1, 10'h2A5, 32'h1234_5678);
        do_txn(4, 1'b0);
        chk("t5_err_clear", timeout_err_o, 0);

        // Stray mem_ready in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = {4{32'hFEED_F00D}};
            tick();
            mem_ready_i = 1'b0;
            mem_rdata_i = Junk;
            chk("t6_stray", {ic_done_o, dc_done_o, mem_read_en_o, mem_write_en_o}, 0);
        end
        chk("t6_addr_hold", mem_addr_o, 10'h2A5);
        chk("t6_wdata_hold", mem_wdata_o, 32'h1234_5678);
        chk("t6_ic_rdata_hold", ic_rdata_o, exp_rd_ic);
        chk("t6_dc_rdata_hold", dc_rdata_o, exp_rd_dc);

        // Requester inputs change during ACCESS; latched values must be used
        issue_dc(1'b0, 10'h155, 32'h0BAD_CAFE);
        do_txn(8, 1'b1);
        chk("t6_err_clear", timeout_err_o, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
